// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and field widths for the LED pattern controller.
package led_ctrl_pkg;

   localparam int unsigned MODE_W   = 2;
   localparam int unsigned PERIOD_W = 16;

   typedef enum logic [MODE_W-1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides sys_clk by DIV; tick is a registered one-cycle pulse as the count wraps to 0.
module tick_prescaler #(
   parameter int unsigned DIV = 2
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt <= '0;
         tick  <= 1'b0;
      end else if (r_cnt == CNT_W'(DIV - 1)) begin
         r_cnt <= '0;
         tick  <= 1'b1;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: OFF/ON/BLINK/BREATHE per channel on a shared tick time base.
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 128000000,
   parameter int unsigned TICK_HZ  = 1000,
   parameter int unsigned N_CH     = 4,
   parameter int unsigned PWM_BITS = 8,
   localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [MODE_W-1:0]   cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   output logic [N_CH-1:0]     led_out,
   output logic                tick_out
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam logic [PWM_BITS-1:0] LVL_TOP = '1;

   logic                w_tick;
   logic                r_ready;
   logic [PWM_BITS-1:0] r_pwm;

   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tick    (w_tick)
   );

   assign tick_out  = w_tick;
   assign cfg_ready = r_ready;

   // Handshake readiness and the free-running breathe PWM counter.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_ready <= 1'b0;
         r_pwm   <= '0;
      end else begin
         r_ready <= 1'b1;
         r_pwm   <= r_pwm + PWM_BITS'(1);
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      led_mode_e           r_mode;
      logic [PERIOD_W-1:0] r_per;
      logic [PERIOD_W-1:0] r_cnt;
      logic                r_blink;
      logic [PWM_BITS-1:0] r_lvl;
      logic                r_down;
      logic                r_led;
      logic                w_acc;
      logic                w_wrap;
      logic [PERIOD_W-1:0] w_per_eff;
      logic [PERIOD_W-1:0] w_cnt_nxt;

      // Out-of-range cfg_ch values match no channel, so they complete the handshake as no-ops.
      assign w_acc     = cfg_valid && r_ready && (cfg_ch == CH_W'(gi));
      assign w_per_eff = (r_per == '0) ? PERIOD_W'(1) : r_per;
      assign w_cnt_nxt = r_cnt + PERIOD_W'(1);
      assign w_wrap    = (w_cnt_nxt >= w_per_eff);
      assign led_out[gi] = r_led;

      always_ff @(posedge sys_clk) begin
         if (sys_rst) begin
            r_mode  <= LED_OFF;
            r_per   <= PERIOD_W'(1);
            r_cnt   <= '0;
            r_blink <= 1'b0;
            r_lvl   <= '0;
            r_down  <= 1'b0;
            r_led   <= 1'b0;
         end else begin
            // An accept takes priority over a coincident tick on this channel.
            if (w_acc) begin
               r_mode  <= led_mode_e'(cfg_mode);
               r_per   <= cfg_period;
               r_cnt   <= '0;
               r_blink <= 1'b0;
               r_lvl   <= '0;
               r_down  <= 1'b0;
            end else if (w_tick && (r_mode == LED_BLINK || r_mode == LED_BREATHE)) begin
               r_cnt <= w_wrap ? '0 : w_cnt_nxt;
               if (w_wrap && r_mode == LED_BLINK) begin
                  r_blink <= ~r_blink;
               end else if (w_wrap && !r_down) begin
                  r_lvl <= r_lvl + PWM_BITS'(1);
                  if (r_lvl == LVL_TOP - PWM_BITS'(1)) r_down <= 1'b1;
               end else if (w_wrap) begin
                  r_lvl <= r_lvl - PWM_BITS'(1);
                  if (r_lvl == PWM_BITS'(1)) r_down <= 1'b0;
               end
            end

            case (r_mode)
               LED_OFF:     r_led <= 1'b0;
               LED_ON:      r_led <= 1'b1;
               LED_BLINK:   r_led <= r_blink;
               LED_BREATHE: r_led <= (r_pwm < r_lvl);
               default:     r_led <= 1'b0;
            endcase
         end
      end
   end

endmodule
